uart_rx_ctrl: RTL and testbench

//  Sequences and configures one uart_rx receiver and buffers its frames for a host.

---
 rtl/uart_rx_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Sequences and configures one uart_rx receiver and buffers its completed
//   frames, with their error flags, in a FIFO for a host.
//
//   Optional feature macro: UART_RX_CTRL_TIMEOUT_EN
//     defined   -> an idle counter raises a sticky timeout (and irq) when frames
//                  sit unread in the FIFO for TIMEOUT cycles while running.
//     undefined -> no idle counter; timeout is constant 0.
//
// Ports
//   reset, clock_x8       asynchronous active-low reset, 8x bit-rate clock
//   cfg_we/enable/parity/width
//                         one-cycle configuration write from the host
//   rx_reset_n, rx_parity, rx_width
//                         reset and configuration driven to uart_rx
//   rx_req_store, rx_bits, rx_error_parity, rx_error_stop_bit
//                         frame outputs from uart_rx
//   rd_req                host pop request (one cycle)
//   rd_valid, rd_data, rd_err_parity, rd_err_stop
//                         registered pop result, valid one cycle after rd_req
//   status_empty/full/count/overrun
//                         FIFO status
//   irq                   registered (count >= THRESHOLD) | overrun | timeout
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int THRESHOLD = 4,
    parameter int TIMEOUT   = 80
) (
    input  logic              reset,
    input  logic              clock_x8,
    input  logic              cfg_we,
    input  logic              cfg_enable,
    input  logic [1:0]        cfg_parity,
    input  logic [3:0]        cfg_width,
    output logic              rx_reset_n,
    output logic [1:0]        rx_parity,
    output logic [3:0]        rx_width,
    input  logic              rx_req_store,
    input  logic [15:0]       rx_bits,
    input  logic              rx_error_parity,
    input  logic              rx_error_stop_bit,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [15:0]       rd_data,
    output logic              rd_err_parity,
    output logic              rd_err_stop,
    output logic              status_empty,
    output logic              status_full,
    output logic [ADDR_W:0]   status_count,
    output logic              status_overrun,
    output logic              irq
);

    // Elaboration-time sanity check of the parameter set.
    if ((DEPTH != (1 << ADDR_W)) || (DEPTH < 2) || (DEPTH > 64) ||
        (THRESHOLD < 1) || (THRESHOLD > DEPTH) || (TIMEOUT < 1)) begin : g_param_check
        $error("uart_rx_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARM      = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Control FSM and configuration registers
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [1:0]  parity_q, parity_d;
    logic [3:0]  width_q, width_d;
    logic        rx_reset_n_q;
    logic        enter_disabled;

    // NOTE: combinational blocks assign every output a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        width_d  = width_q;
        case (state_q)
            ST_DISABLED: begin
                if (cfg_we) begin
                    parity_d = cfg_parity;
                    width_d  = cfg_width;
                    if (cfg_enable) state_d = ST_ARM;
                end
            end
            // Single cycle so uart_rx leaves reset with configuration stable.
            ST_ARM:  state_d = ST_RUN;
            ST_RUN: begin
                // Writes with enable=1 while running are ignored entirely.
                if (cfg_we && !cfg_enable) state_d = ST_DISABLED;
            end
            default: state_d = ST_DISABLED;
        endcase
    end

    assign enter_disabled = (state_q != ST_DISABLED) && (state_d == ST_DISABLED);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_x8 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_DISABLED;
            parity_q     <= 2'b00;
            width_q      <= 4'd8;
            rx_reset_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            parity_q     <= parity_d;
            width_q      <= width_d;
            // Registered from next state so the uart_rx reset is glitch-free.
            rx_reset_n_q <= (state_d != ST_DISABLED);
        end
    end

    assign rx_reset_n = rx_reset_n_q;
    assign rx_parity  = parity_q;
    assign rx_width   = width_q;

    // ------------------------------------------------------------------------
    // Frame capture on the rising edge of rx_req_store
    // ------------------------------------------------------------------------
    logic        req_q;
    logic        push_evt;
    logic [16:0] mask_wide;
    logic [15:0] mask;
    logic [17:0] entry;

    assign push_evt  = (state_q == ST_RUN) && rx_req_store && !req_q;
    // Width 0 encodes 16 data bits.
    assign mask_wide = (17'd1 << width_q) - 17'd1;
    assign mask      = (width_q == 4'd0) ? 16'hFFFF : mask_wide[15:0];
    assign entry     = {rx_error_stop_bit, rx_error_parity, rx_bits & mask};

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    logic [17:0]     mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0] count_q, count_d;
    logic            empty, full;
    logic            do_pop, do_push;
    logic            overrun_q;
    logic            rd_valid_q, rd_err_parity_q, rd_err_stop_q;
    logic [15:0]     rd_data_q;
    logic            irq_q;
    logic            timeout_flag;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (ADDR_W + 1)'(DEPTH));
    assign do_pop  = rd_req && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign do_push = push_evt && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; only the pointers and count that
    // qualify its contents do, which keeps it mappable to plain RAM.
    always_ff @(posedge clock_x8) begin
        if (do_push) mem_q[wr_ptr_q] <= entry;
    end

    always_ff @(posedge clock_x8 or negedge reset) begin
        if (!reset) begin
            req_q           <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            overrun_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= 16'h0000;
            rd_err_parity_q <= 1'b0;
            rd_err_stop_q   <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            req_q   <= enter_disabled ? 1'b0 : rx_req_store;
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            if (enter_disabled)
                overrun_q <= 1'b0;
            else if (push_evt && full && !do_pop)
                overrun_q <= 1'b1;

            rd_valid_q <= do_pop;
            if (do_pop) begin
                rd_data_q       <= mem_q[rd_ptr_q][15:0];
                rd_err_parity_q <= mem_q[rd_ptr_q][16];
                rd_err_stop_q   <= mem_q[rd_ptr_q][17];
            end

            irq_q <= (count_q >= (ADDR_W + 1)'(THRESHOLD)) || overrun_q || timeout_flag;
        end
    end

    // ------------------------------------------------------------------------
    // Optional idle timeout
    // ------------------------------------------------------------------------
`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q;
    logic              timeout_q;

    always_ff @(posedge clock_x8 or negedge reset) begin
        if (!reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            // Counter saturates at TIMEOUT and holds (without counting) outside RUN.
            if (do_push || do_pop || empty || enter_disabled)
                idle_q <= '0;
            else if ((state_q == ST_RUN) && (idle_q != IDLE_W'(TIMEOUT)))
                idle_q <= idle_q + 1'b1;

            if (enter_disabled || do_pop || (count_d == '0))
                timeout_q <= 1'b0;
            else if ((state_q == ST_RUN) && (idle_q == IDLE_W'(TIMEOUT)))
                timeout_q <= 1'b1;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_err_parity  = rd_err_parity_q;
    assign rd_err_stop    = rd_err_stop_q;
    assign status_empty   = empty;
    assign status_full    = full;
    assign status_count   = count_q;
    assign status_overrun = overrun_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Directed self-checking bench for uart_rx_ctrl (DEPTH=8, THRESHOLD=4,
//   TIMEOUT=80). Drives the uart_rx side directly: a frame is rx_req_store
//   high for one cycle with rx_bits and the error flags presented.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic        clock_x8 = 1'b0;
    logic        reset    = 1'b0;
    logic        cfg_we = 1'b0, cfg_enable = 1'b0;
    logic [1:0]  cfg_parity = 2'b00;
    logic [3:0]  cfg_width = 4'd8;
    logic        rx_reset_n;
    logic [1:0]  rx_parity;
    logic [3:0]  rx_width;
    logic        rx_req_store = 1'b0;
    logic [15:0] rx_bits = 16'h0000;
    logic        rx_error_parity = 1'b0, rx_error_stop_bit = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_err_parity, rd_err_stop;
    logic        status_empty, status_full, status_overrun, irq;
    logic [3:0]  status_count;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(.DEPTH(8), .ADDR_W(3), .THRESHOLD(4), .TIMEOUT(80)) dut (
        .reset(reset), .clock_x8(clock_x8),
        .cfg_we(cfg_we), .cfg_enable(cfg_enable), .cfg_parity(cfg_parity), .cfg_width(cfg_width),
        .rx_reset_n(rx_reset_n), .rx_parity(rx_parity), .rx_width(rx_width),
        .rx_req_store(rx_req_store), .rx_bits(rx_bits),
        .rx_error_parity(rx_error_parity), .rx_error_stop_bit(rx_error_stop_bit),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_err_parity(rd_err_parity), .rd_err_stop(rd_err_stop),
        .status_empty(status_empty), .status_full(status_full), .status_count(status_count),
        .status_overrun(status_overrun), .irq(irq)
    );

    always #5 clock_x8 = ~clock_x8;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock_x8);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input logic en, input logic [1:0] par, input logic [3:0] w);
        cfg_we = 1'b1; cfg_enable = en; cfg_parity = par; cfg_width = w;
        tick();
        cfg_we = 1'b0;
    endtask

    // Write + enable from DISABLED, then wait out ARM so the FSM is in RUN.
    task automatic enable_cfg(input logic [1:0] par, input logic [3:0] w);
        cfg_write(1'b1, par, w);
        tick();
    endtask

    task automatic send_frame(input logic [15:0] bits, input logic perr, input logic serr);
        rx_bits = bits; rx_error_parity = perr; rx_error_stop_bit = serr;
        rx_req_store = 1'b1;
        tick();
        rx_req_store = 1'b0;
        tick();
    endtask

    // Leaves the bench one sample after the pop edge, where rd_valid is high.
    task automatic pop();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        ticks(3);
        check("rst_rx_reset_n", rx_reset_n, 0);
        check("rst_rx_width",   rx_width, 8);
        check("rst_rx_parity",  rx_parity, 0);
        check("rst_empty",      status_empty, 1);
        check("rst_count",      status_count, 0);
        check("rst_irq",        irq, 0);
        check("rst_rd_valid",   rd_valid, 0);
        check("rst_overrun",    status_overrun, 0);
        @(negedge clock_x8);
        reset = 1'b1;
        tick();

        // ---------------- 1: enable, basic frame ----------------
        check("t1_rxrst_before", rx_reset_n, 0);
        cfg_write(1'b1, 2'b00, 4'd8);
        check("t1_rxrst_arm", rx_reset_n, 1);
        tick();
        check("t1_rxrst_run", rx_reset_n, 1);
        send_frame(16'h00A5, 1'b0, 1'b0);
        check("t1_count", status_count, 1);
        check("t1_irq",   irq, 0);
        pop();
        check("t1_rd_valid", rd_valid, 1);
        check("t1_rd_data",  rd_data, 16'h00A5);
        check("t1_rd_errs",  {rd_err_stop, rd_err_parity}, 0);
        tick();
        check("t1_rd_valid_pulse", rd_valid, 0);
        check("t1_empty", status_empty, 1);
        pop();
        check("t1_empty_pop_valid", rd_valid, 0);
        check("t1_empty_pop_hold",  rd_data, 16'h00A5);

        // ---------------- 2: error flags ----------------
        cfg_write(1'b0, 2'b00, 4'd8);
        check("t2_rxrst_dis", rx_reset_n, 0);
        enable_cfg(2'b11, 4'd8);
        check("t2_rx_parity", rx_parity, 2'b11);
        send_frame(16'h0033, 1'b1, 1'b0);
        pop();
        check("t2_par_data", rd_data, 16'h0033);
        check("t2_par_err",  {rd_err_stop, rd_err_parity}, 2'b01);
        send_frame(16'h0044, 1'b0, 1'b1);
        pop();
        check("t2_stop_err", {rd_err_stop, rd_err_parity}, 2'b10);

        // ---------------- 3: width masking ----------------
        cfg_write(1'b0, 2'b00, 4'd8);
        enable_cfg(2'b00, 4'd5);
        check("t3_rx_width5", rx_width, 5);
        send_frame(16'hFFE3, 1'b0, 1'b0);
        pop();
        check("t3_mask5", rd_data, 16'h0003);
        cfg_write(1'b0, 2'b00, 4'd8);
        enable_cfg(2'b00, 4'd0);
        check("t3_rx_width0", rx_width, 0);
        send_frame(16'hBEEF, 1'b0, 1'b0);
        pop();
        check("t3_mask16", rd_data, 16'hBEEF);

        // ---------------- 4: full, simultaneous push/pop, overrun ----------------
        cfg_write(1'b0, 2'b00, 4'd8);
        enable_cfg(2'b00, 4'd8);
        for (int i = 0; i < 8; i++) send_frame(16'h0010 + 16'(i), 1'b0, 1'b0);
        check("t4_full",    status_full, 1);
        check("t4_count8",  status_count, 8);
        check("t4_irq_thr", irq, 1);
        // Push and pop in the same cycle while full.
        rx_bits = 16'h0018; rx_req_store = 1'b1; rd_req = 1'b1;
        tick();
        rx_req_store = 1'b0; rd_req = 1'b0;
        check("t4_sim_data",    rd_data, 16'h0010);
        check("t4_sim_count",   status_count, 8);
        check("t4_sim_overrun", status_overrun, 0);
        tick();
        send_frame(16'h0019, 1'b0, 1'b0);
        check("t4_ovr",       status_overrun, 1);
        check("t4_ovr_count", status_count, 8);
        pop();
        check("t4_order", rd_data, 16'h0011);
        check("t4_count7", status_count, 7);

        // ---------------- 5: config while running, disable ----------------
        cfg_write(1'b1, 2'b00, 4'd7);
        check("t5_width_kept", rx_width, 8);
        check("t5_still_run",  rx_reset_n, 1);
        cfg_write(1'b0, 2'b00, 4'd8);
        check("t5_rxrst_dis",  rx_reset_n, 0);
        check("t5_ovr_clear",  status_overrun, 0);
        check("t5_fifo_kept",  status_count, 7);
        pop();
        check("t5_read_dis", rd_data, 16'h0012);
        check("t5_read_valid", rd_valid, 1);

        // ---------------- async reset mid-operation ----------------
        tick();
        #3 reset = 1'b0;
        #1;
        check("ar_count",    status_count, 0);
        check("ar_empty",    status_empty, 1);
        check("ar_rd_data",  rd_data, 0);
        check("ar_irq",      irq, 0);
        check("ar_rx_width", rx_width, 8);
        @(negedge clock_x8);
        reset = 1'b1;
        tick();

        // ---------------- 6: idle timeout ----------------
        enable_cfg(2'b00, 4'd8);
        send_frame(16'h0055, 1'b0, 1'b0);
        check("t6_count1", status_count, 1);
        ticks(40);
        check("t6_irq_early", irq, 0);
        ticks(50);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        check("t6_irq_timeout", irq, 1);
`else
        check("t6_irq_no_timeout", irq, 0);
`endif
        pop();
        check("t6_data", rd_data, 16'h0055);
        tick();
        check("t6_irq_after_pop", irq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
